// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Operation codes, FSM states and default busy-cycle counts used by mdu and its decode.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed combinationally at issue and held in res until the programmed
// latency has elapsed, then committed to HI/LO. Define MDU_DIV_EN to build div/divu;
// without it ops 3/4 decode as no-ops and no divider is generated.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDU_op,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_mul, is_div;
    logic [63:0] mul_s, mul_u, res_calc;

    // Decode the E-stage op into the multi-cycle classes.
    always_comb begin
        is_mul = (E_MDU_op == MDU_MULT) || (E_MDU_op == MDU_MULTU);
`ifdef MDU_DIV_EN
        is_div = (E_MDU_op == MDU_DIV) || (E_MDU_op == MDU_DIVU);
`else
        is_div = 1'b0;
`endif
    end

`ifdef MDU_DIV_EN
    logic        div_signed;
    logic [31:0] div_a, div_b, div_q, div_r;

    // Single unsigned divider shared by div/divu; signed ops divide magnitudes and fix signs.
    always_comb begin
        div_signed = (E_MDU_op == MDU_DIV);
        div_a = (div_signed && E_RD1[31]) ? (~E_RD1 + 32'd1) : E_RD1;
        div_b = (div_signed && E_RD2[31]) ? (~E_RD2 + 32'd1) : E_RD2;
        // Divide-by-zero result is discarded; a safe divisor keeps the datapath defined.
        if (div_b == 32'd0) begin
            div_b = 32'd1;
        end
        div_q = div_a / div_b;
        div_r = div_a % div_b;
        if (div_signed && (E_RD1[31] ^ E_RD2[31])) begin
            div_q = ~div_q + 32'd1;
        end
        // Remainder follows the dividend's sign.
        if (div_signed && E_RD1[31]) begin
            div_r = ~div_r + 32'd1;
        end
    end
`endif

    // Arithmetic: full 64-bit products and the result selected for latching at issue.
    always_comb begin
        mul_s    = 64'($signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2}));
        mul_u    = {32'd0, E_RD1} * {32'd0, E_RD2};
        res_calc = (E_MDU_op == MDU_MULT) ? mul_s : mul_u;
`ifdef MDU_DIV_EN
        if (is_div) begin
            res_calc = {div_r, div_q};
        end
`endif
    end

    // Next-state logic for the FSM, latency counter, pending result and HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (is_mul || is_div) begin
                    res_d   = res_calc;
                    div0_d  = is_div && (E_RD2 == 32'd0);
                    cnt_d   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    state_d = ST_BUSY;
                end else if (E_MDU_op == MDU_MTHI) begin
                    hi_d = E_RD1;
                end else if (E_MDU_op == MDU_MTLO) begin
                    lo_d = E_RD1;
                end
            end
            ST_BUSY: begin
                // Ops arriving here are ignored; the hazard unit never issues them.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!div0_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            div0_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status and register outputs.
    always_comb begin
        E_start = (state_q == ST_IDLE) && (is_mul || is_div);
        E_busy  = (state_q == ST_BUSY);
        E_HI    = hi_q;
        E_LO    = lo_q;
    end

endmodule
